// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned INSN_W     = 32;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: redirect target, sequential pc+4, or hold.
// Alignment handling depends on PC_ALIGN_CHECK_EN.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc_next,
  output logic              fault_req
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSN_BYTES - 1);

  logic [ADDR_W-1:0] target;

  always_comb begin
`ifdef PC_ALIGN_CHECK_EN
    target    = redirect_pc;
    fault_req = redirect_valid && ((redirect_pc & ALIGN_MASK) != '0);
`else
    // Misaligned targets are silently rounded down to an instruction boundary.
    target    = redirect_pc & ~ALIGN_MASK;
    fault_req = 1'b0;
`endif
    if (redirect_valid)
      pc_next = target;
    else if (advance)
      pc_next = pc + ADDR_W'(INSN_BYTES);
    else
      pc_next = pc;
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer with decode handshake.
// Optional misaligned-redirect fault state enabled by PC_ALIGN_CHECK_EN.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W       = 64,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req_valid,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_req_ready,
  input  logic              i_imem_rsp_valid,
  input  logic [INSN_W-1:0] i_imem_rsp_data,
  output logic              o_insn_valid,
  output logic [INSN_W-1:0] o_insn,
  output logic [ADDR_W-1:0] o_insn_pc,
  input  logic              i_dec_ready,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_fault
);
  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              drop;
  logic              advance;
  logic              fault_req;
  logic [INSN_W-1:0] insn;
  logic [ADDR_W-1:0] insn_pc;

  assign advance = (state == WAIT) && i_imem_rsp_valid && !drop && !i_redirect_valid;

  pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
    .pc             (pc),
    .redirect_valid (i_redirect_valid),
    .redirect_pc    (i_redirect_pc),
    .advance        (advance),
    .pc_next        (pc_next),
    .fault_req      (fault_req)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= REQ;
      pc      <= RESET_VECTOR;
      drop    <= 1'b0;
      insn    <= '0;
      insn_pc <= '0;
    end else if (state != FAULT) begin
      pc <= pc_next;
      if (fault_req) begin
        state <= FAULT;
        drop  <= 1'b0;
      end else begin
        case (state)
          REQ: begin
            if (i_imem_req_ready) begin
              state <= WAIT;
              drop  <= i_redirect_valid;
            end
          end
          WAIT: begin
            if (i_redirect_valid) begin
              // A response coinciding with the redirect is the one being dropped,
              // so nothing remains outstanding and fetch restarts immediately.
              if (i_imem_rsp_valid) begin
                drop  <= 1'b0;
                state <= REQ;
              end else begin
                drop <= 1'b1;
              end
            end else if (i_imem_rsp_valid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= REQ;
              end else begin
                insn    <= i_imem_rsp_data;
                insn_pc <= pc;
                state   <= HOLD;
              end
            end
          end
          HOLD: begin
            if (i_redirect_valid || i_dec_ready)
              state <= REQ;
          end
          default: state <= REQ;
        endcase
      end
    end
  end

  assign o_imem_req_valid = (state == REQ) && !i_rst;
  assign o_imem_addr      = pc;
  assign o_insn_valid     = (state == HOLD);
  assign o_insn           = insn;
  assign o_insn_pc        = insn_pc;
  assign o_fault          = (state == FAULT);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized fetch-stream model.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        o_imem_req_valid;
  logic [63:0] o_imem_addr;
  logic        i_imem_req_ready;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        o_insn_valid;
  logic [31:0] o_insn;
  logic [63:0] o_insn_pc;
  logic        i_dec_ready;
  logic        i_redirect_valid;
  logic [63:0] i_redirect_pc;
  logic        o_fault;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  // memory model state
  logic        mem_pending;
  int unsigned mem_delay;
  logic [63:0] mem_addr;
  int unsigned mem_lat;
  logic        ovr_en;
  logic [31:0] ovr_data;

  // per-cycle observations
  logic        acc;
  logic [63:0] acc_addr;
  logic        del;
  logic [63:0] del_pc;
  logic [31:0] del_insn;

  pc_fetch_unit #(.ADDR_W(64), .RESET_VECTOR(64'h0)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_addr      (o_imem_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_insn_valid     (o_insn_valid),
    .o_insn           (o_insn),
    .o_insn_pc        (o_insn_pc),
    .i_dec_ready      (i_dec_ready),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_fault          (o_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  // One clock: drive inputs at negedge, note handshakes, advance memory model across posedge.
  task automatic cycle(input logic rdy, input logic drdy, input logic redir, input logic [63:0] tgt);
    logic fired;
    i_imem_req_ready = rdy;
    i_dec_ready      = drdy;
    i_redirect_valid = redir;
    i_redirect_pc    = tgt;
    i_imem_rsp_valid = mem_pending && (mem_delay == 0);
    i_imem_rsp_data  = ovr_en ? ovr_data : word_of(mem_addr);
    #1;
    acc      = o_imem_req_valid && rdy;
    acc_addr = o_imem_addr;
    del      = o_insn_valid && drdy && !redir;
    del_pc   = o_insn_pc;
    del_insn = o_insn;
    fired    = i_imem_rsp_valid;
    @(posedge clk);
    if (fired) mem_pending = 1'b0;
    else if (mem_pending && mem_delay > 0) mem_delay = mem_delay - 1;
    if (acc) begin
      mem_pending = 1'b1;
      mem_addr    = acc_addr;
      mem_delay   = mem_lat;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_dec_ready = 1'b0;
    i_redirect_valid = 1'b0; i_redirect_pc = '0; i_imem_rsp_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_pending = 1'b0; mem_delay = 0; ovr_en = 1'b0; mem_lat = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (o_imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %0b want 0", o_imem_req_valid); else pass_cnt++;
    chk_cnt++; if (o_imem_addr !== 64'h0) $display("FAIL reset_addr: got %h want 0", o_imem_addr); else pass_cnt++;
    chk_cnt++; if (o_insn_valid !== 1'b0) $display("FAIL reset_insn_valid: got %0b want 0", o_insn_valid); else pass_cnt++;
    chk_cnt++; if (o_insn !== 32'h0) $display("FAIL reset_insn: got %h want 0", o_insn); else pass_cnt++;
    chk_cnt++; if (o_insn_pc !== 64'h0) $display("FAIL reset_insn_pc: got %h want 0", o_insn_pc); else pass_cnt++;
    chk_cnt++; if (o_fault !== 1'b0) $display("FAIL reset_fault: got %0b want 0", o_fault); else pass_cnt++;
    apply_reset();
  endtask

  task automatic test_sequential();
    logic [63:0] acc_q[$];
    logic [63:0] del_q[$];
    apply_reset();
    repeat (9) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (acc) acc_q.push_back(acc_addr);
      if (del) del_q.push_back(del_pc);
    end
    chk_cnt++; if (acc_q.size() != 3) $display("FAIL seq_req_count: got %0d want 3", acc_q.size()); else pass_cnt++;
    chk_cnt++; if (del_q.size() != 3) $display("FAIL seq_del_count: got %0d want 3", del_q.size()); else pass_cnt++;
    for (int i = 0; i < acc_q.size() && i < 3; i++) begin
      chk_cnt++; if (acc_q[i] !== 64'(i * 4)) $display("FAIL seq_req_addr%0d: got %h want %h", i, acc_q[i], 64'(i * 4)); else pass_cnt++;
    end
    for (int i = 0; i < del_q.size() && i < 3; i++) begin
      chk_cnt++; if (del_q[i] !== 64'(i * 4)) $display("FAIL seq_del_pc%0d: got %h want %h", i, del_q[i], 64'(i * 4)); else pass_cnt++;
    end
  endtask

  task automatic test_decode_stall();
    apply_reset();
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      chk_cnt++; if (o_insn_valid !== 1'b1) $display("FAIL stall_valid%0d: got %0b want 1", i, o_insn_valid); else pass_cnt++;
      chk_cnt++; if (o_insn !== word_of(64'h0) || o_insn_pc !== 64'h0)
        $display("FAIL stall_data%0d: got %h@%h want %h@0", i, o_insn, o_insn_pc, word_of(64'h0)); else pass_cnt++;
      chk_cnt++; if (o_imem_req_valid !== 1'b0) $display("FAIL stall_noreq%0d: got %0b want 0", i, o_imem_req_valid); else pass_cnt++;
      cycle(1'b0, 1'b0, 1'b0, '0);
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk_cnt++; if (!(del && del_pc === 64'h0)) $display("FAIL stall_release: got del=%0b pc=%h want 1/0", del, del_pc); else pass_cnt++;
    chk_cnt++; if (!(o_imem_req_valid === 1'b1 && o_imem_addr === 64'h4))
      $display("FAIL stall_next_req: got %0b/%h want 1/4", o_imem_req_valid, o_imem_addr); else pass_cnt++;
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    mem_lat = 2;
    cycle(1'b1, 1'b0, 1'b0, '0);
    ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    cycle(1'b0, 1'b0, 1'b1, 64'h1000);
    for (int i = 0; i < 3; i++) begin
      chk_cnt++; if (o_insn_valid !== 1'b0) $display("FAIL rw_discard%0d: got %0b want 0", i, o_insn_valid); else pass_cnt++;
      cycle(1'b0, 1'b0, 1'b0, '0);
    end
    chk_cnt++; if (!(o_imem_req_valid === 1'b1 && o_imem_addr === 64'h1000))
      $display("FAIL rw_next_req: got %0b/%h want 1/1000", o_imem_req_valid, o_imem_addr); else pass_cnt++;
    ovr_en = 1'b0; mem_lat = 0;
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk_cnt++; if (!(o_insn_valid === 1'b1 && o_insn_pc === 64'h1000 && o_insn === word_of(64'h1000)))
      $display("FAIL rw_deliver: got %0b %h@%h want 1 %h@1000", o_insn_valid, o_insn, o_insn_pc, word_of(64'h1000)); else pass_cnt++;
  endtask

  task automatic test_redirect_hold();
    // continues from HOLD left by test_redirect_wait
    cycle(1'b0, 1'b1, 1'b1, 64'h2000);
    chk_cnt++; if (o_insn_valid !== 1'b0) $display("FAIL rh_squash: got %0b want 0", o_insn_valid); else pass_cnt++;
    chk_cnt++; if (!(o_imem_req_valid === 1'b1 && o_imem_addr === 64'h2000))
      $display("FAIL rh_next_req: got %0b/%h want 1/2000", o_imem_req_valid, o_imem_addr); else pass_cnt++;
  endtask

  task automatic test_wrap();
    apply_reset();
    cycle(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk_cnt++; if (!(acc && acc_addr === 64'hFFFF_FFFF_FFFF_FFFC)) $display("FAIL wrap_req: got %0b/%h want 1/fffffffffffffffc", acc, acc_addr); else pass_cnt++;
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk_cnt++; if (!(del && del_pc === 64'hFFFF_FFFF_FFFF_FFFC)) $display("FAIL wrap_del: got %0b/%h want 1/fffffffffffffffc", del, del_pc); else pass_cnt++;
    chk_cnt++; if (!(o_imem_req_valid === 1'b1 && o_imem_addr === 64'h0))
      $display("FAIL wrap_next_req: got %0b/%h want 1/0", o_imem_req_valid, o_imem_addr); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    apply_reset();
    cycle(1'b0, 1'b0, 1'b1, 64'h1002);
`ifdef PC_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (!(o_fault === 1'b1 && o_imem_req_valid === 1'b0 && o_insn_valid === 1'b0))
        $display("FAIL mis_fault%0d: got f=%0b r=%0b v=%0b want 1/0/0", i, o_fault, o_imem_req_valid, o_insn_valid); else pass_cnt++;
      cycle(1'b1, 1'b1, 1'b0, '0);
    end
    apply_reset();
    chk_cnt++; if (!(o_fault === 1'b0 && o_imem_req_valid === 1'b1 && o_imem_addr === 64'h0))
      $display("FAIL mis_reset_clear: got f=%0b r=%0b a=%h want 0/1/0", o_fault, o_imem_req_valid, o_imem_addr); else pass_cnt++;
`else
    chk_cnt++; if (!(o_imem_req_valid === 1'b1 && o_imem_addr === 64'h1000 && o_fault === 1'b0))
      $display("FAIL mis_mask: got r=%0b a=%h f=%0b want 1/1000/0", o_imem_req_valid, o_imem_addr, o_fault); else pass_cnt++;
`endif
  endtask

  // Fetch-stream model: requests and deliveries each walk sequentially from the last redirect target.
  task automatic test_random();
    logic [63:0] exp_req;
    logic [63:0] exp_del;
    logic [63:0] tgt;
    logic        rdy, drdy, redir;
    int unsigned n_del;
    apply_reset();
    exp_req = 64'h0; exp_del = 64'h0; n_del = 0;
    for (int c = 0; c < 3000; c++) begin
      mem_lat = $urandom_range(0, 3);
      rdy   = ($urandom_range(0, 3) != 0);
      drdy  = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      tgt   = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
      cycle(rdy, drdy, redir, tgt);
      if (acc) begin
        chk_cnt++; if (acc_addr !== exp_req) $display("FAIL rnd_req c%0d: got %h want %h", c, acc_addr, exp_req); else pass_cnt++;
      end
      if (del) begin
        n_del++;
        chk_cnt++; if (del_pc !== exp_del || del_insn !== word_of(exp_del))
          $display("FAIL rnd_del c%0d: got %h@%h want %h@%h", c, del_insn, del_pc, word_of(exp_del), exp_del); else pass_cnt++;
        exp_del = exp_del + 64'd4;
      end
      if (redir) begin
        exp_req = tgt;
        exp_del = tgt;
      end else if (acc) begin
        exp_req = acc_addr + 64'd4;
      end
      chk_cnt++; if (o_fault !== 1'b0) $display("FAIL rnd_fault c%0d: got %0b want 0", c, o_fault); else pass_cnt++;
    end
    chk_cnt++; if (n_del < 100) $display("FAIL rnd_progress: got %0d deliveries want >=100", n_del); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0;
    i_dec_ready = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0;
    mem_pending = 1'b0; mem_delay = 0; mem_addr = '0; mem_lat = 0; ovr_en = 1'b0; ovr_data = '0;
    test_reset();
    test_sequential();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_misaligned();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
